// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bundles the instruction-memory request/response channel,
// the redirect input and the decoder handoff channel of the fetch stage.
// master = fetch unit side, slave = memory/decoder/branch-unit side.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage. Holds the PC, issues word-aligned
// fetches, buffers in-order responses in a small FIFO and hands one
// instruction per cycle to the decoder. A redirect flushes the buffer and
// discards responses to fetches already in flight before fetching resumes.
// Optional build macro: IFETCH_PERF_CNT_EN adds perf_fetched/perf_flushed.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_flushed
`endif
);

  localparam int          AW  = $clog2(BUF_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;       // PC of the next response that will be kept
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   buf_word [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];

  logic          redirect;
  logic          rsp;
  logic          req_valid;
  logic          req_fire;
  logic          instr_valid;
  logic          push;
  logic          drop;
  logic          pop;
  logic [CW:0]   in_use;
  logic [CW-1:0] redir_drop;
  logic [31:0]   redir_pc;
  logic          unused_redirect_lsb;

  assign redirect = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Slots are reserved at issue time, so buffered plus in-flight bounds issue.
  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  assign req_valid = (state == S_RUN) && !redirect && (in_use < (CW+1)'(BUF_DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign push = rsp && (drop_cnt == '0) && !redirect;
  assign drop = rsp && !push;

  assign instr_valid = (count != '0) && !redirect;
  assign pop         = instr_valid && bus.instr_ready;

  // Responses still owed to fetches issued before the redirect.
  assign redir_drop = outstanding - {{(CW-1){1'b0}}, rsp};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = instr_valid;
  assign bus.instruction    = instr_valid ? buf_word[rd_ptr] : NOP;
  assign bus.instr_pc       = instr_valid ? buf_pc[rd_ptr]   : 32'h0;

  // Control state: FSM, PC tracking, FIFO pointers and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
      if (redirect) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= redir_drop;
        state    <= (redir_drop != '0) ? S_DRAIN : S_RUN;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (drop) drop_cnt <= drop_cnt - 1'b1;
        case (state)
          S_BOOT:  state <= S_RUN;
          S_DRAIN: if (drop && (drop_cnt == CW'(1))) state <= S_RUN;
          default: state <= state;
        endcase
      end
    end
  end

  // FIFO storage: write the kept response with its PC; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_word[wr_ptr] <= bus.imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Handed-off instructions, and entries/responses thrown away by redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_flushed <= 32'h0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_flushed <= perf_flushed + (redirect ? 32'(count) : 32'h0) + 32'(drop);
    end
  end
`endif

endmodule
